// File: rtl/fish_vision_pkg.sv
// Shared types for the fish-counter vision pipeline: coordinate and count
// widths, the committed bounding-box record and the frame state encoding.
package fish_vision_pkg;

  localparam int COORD_W = 16;
  localparam int CNT_W   = 20;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic               valid;
    logic [CNT_W-1:0]   count;
  } bbox_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    COMMIT
  } state_t;

endpackage

// File: rtl/fish_pix_coord_cnt.sv
// Pixel coordinate generator: x/y of the current accepted beat, with
// saturation at the frame limits and a per-beat overflow flag.
module fish_pix_coord_cnt
  import fish_vision_pkg::*;
#(
  parameter int MAX_W = 1024,
  parameter int MAX_H = 768
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               beat,
  input  logic               sof,
  input  logic               eol,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               ovf
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(MAX_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(MAX_H - 1);

  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;
  logic               y_full;

  // x_r/y_r hold the position of the next beat; sof forces the origin.
  assign x = sof ? '0 : x_r;
  assign y = sof ? '0 : y_r;

  // y_full marks an eol on the last row; a further line start overflows.
  assign ovf = beat && ((!eol && (x == X_LAST)) || (y_full && !sof));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_r    <= '0;
      y_r    <= '0;
      y_full <= 1'b0;
    end else if (beat) begin
      if (eol) begin
        x_r <= '0;
        if (y == Y_LAST) begin
          y_r    <= y;
          y_full <= 1'b1;
        end else begin
          y_r    <= y + 1'b1;
          y_full <= 1'b0;
        end
      end else begin
        x_r    <= (x == X_LAST) ? x : x + 1'b1;
        y_r    <= y;
        y_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fish_bbox_extractor.sv
// Per-frame foreground bounding box and pixel count, committed once per frame
// so downstream PIO edge capture sees at most one change per frame.
module fish_bbox_extractor
  import fish_vision_pkg::*;
#(
  parameter int MAX_W      = 1024,
  parameter int MAX_H      = 768,
  parameter int MIN_PIXELS = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_valid,
  input  logic               pix_sof,
  input  logic               pix_eol,
  input  logic               pix_eof,
  input  logic               pix_fg,
  output logic [COORD_W-1:0] box_x0,
  output logic [COORD_W-1:0] box_y0,
  output logic [COORD_W-1:0] box_x1,
  output logic [COORD_W-1:0] box_y1,
  output logic               box_valid,
  output logic [CNT_W-1:0]   pix_count,
  output logic               frame_done,
  output logic               err_sticky
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

  state_t             state;
  bbox_t              box;
  logic [COORD_W-1:0] x, y;
  logic               ovf;
  logic               accept, start;
  logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
  logic [COORD_W-1:0] xmin_n, xmax_n, ymin_n, ymax_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  always_comb begin
    accept = 1'b0;
    case (state)
      IDLE:    accept = pix_valid && pix_sof;
      ACTIVE:  accept = pix_valid;
      COMMIT:  accept = pix_valid && pix_sof;
      default: accept = 1'b0;
    endcase
    start = accept && pix_sof;
  end

  fish_pix_coord_cnt #(
    .MAX_W(MAX_W),
    .MAX_H(MAX_H)
  ) u_coord (
    .clk    (clk),
    .reset_n(reset_n),
    .beat   (accept),
    .sof    (pix_sof),
    .eol    (pix_eol),
    .x      (x),
    .y      (y),
    .ovf    (ovf)
  );

  // A sof beat folds into freshly initialised extremes, so the first
  // foreground pixel of a frame loads all four directly.
  always_comb begin
    xmin_n = start ? '1 : xmin;
    ymin_n = start ? '1 : ymin;
    xmax_n = start ? '0 : xmax;
    ymax_n = start ? '0 : ymax;
    cnt_n  = start ? '0 : cnt;
    if (pix_fg) begin
      if (x < xmin_n) xmin_n = x;
      if (x > xmax_n) xmax_n = x;
      if (y < ymin_n) ymin_n = y;
      if (y > ymax_n) ymax_n = y;
      if (cnt_n != '1) cnt_n = cnt_n + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      box        <= '0;
      frame_done <= 1'b0;
      err_sticky <= 1'b0;
      xmin       <= '1;
      ymin       <= '1;
      xmax       <= '0;
      ymax       <= '0;
      cnt        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (ovf) err_sticky <= 1'b1;

      if (state == ACTIVE && pix_valid && pix_sof) err_sticky <= 1'b1;

      // Commit reads the old frame's accumulators even when a new sof
      // reloads them on this same edge.
      if (state == COMMIT) begin
        frame_done <= 1'b1;
        box.count  <= cnt;
        if (cnt >= MIN_CNT) begin
          box.x0    <= xmin;
          box.y0    <= ymin;
          box.x1    <= xmax;
          box.y1    <= ymax;
          box.valid <= 1'b1;
        end else begin
          box.x0    <= '0;
          box.y0    <= '0;
          box.x1    <= '0;
          box.y1    <= '0;
          box.valid <= 1'b0;
        end
        if (pix_valid && !pix_sof) err_sticky <= 1'b1;
        state <= IDLE;
      end

      if (accept) begin
        xmin <= xmin_n;
        xmax <= xmax_n;
        ymin <= ymin_n;
        ymax <= ymax_n;
        cnt  <= cnt_n;
        if (pix_eof) begin
          state <= COMMIT;
          if (!pix_eol) err_sticky <= 1'b1;
        end else begin
          state <= ACTIVE;
        end
      end
    end
  end

  assign box_x0    = box.x0;
  assign box_y0    = box.y0;
  assign box_x1    = box.x1;
  assign box_y1    = box.y1;
  assign box_valid = box.valid;
  assign pix_count = box.count;

endmodule
